collision_score: RTL

- Consumer end of the pipe-position interface: samples both pipe generators' positions and the bird's Y position every clock.
- Detects collisions with pipes or the floor and drives Lost back to the pipe generators.
- Counts pipes cleared (Score) and keeps a session high score.
- Sits between the pipe generators, the bird physics block and the VGA/score display.

---
 rtl/collision_score_if.sv | 23 ++
 rtl/collision_score.sv | 131 +++++++++++++
 2 files changed

// File: rtl/collision_score_if.sv
// Pipe-position / bird-position bundle consumed by collision_score, plus its game-status results.
interface collision_score_if;
   logic       Start;
   logic [9:0] BirdPosY;
   logic [9:0] PipePosXA;
   logic [9:0] PipePosYA;
   logic [9:0] PipePosXB;
   logic [9:0] PipePosYB;
   logic       Lost;
   logic       Playing;
   logic [9:0] Score;
   logic [9:0] HighScore;

   modport master (
      output Start, BirdPosY, PipePosXA, PipePosYA, PipePosXB, PipePosYB,
      input  Lost, Playing, Score, HighScore
   );

   modport slave (
      input  Start, BirdPosY, PipePosXA, PipePosYA, PipePosXB, PipePosYB,
      output Lost, Playing, Score, HighScore
   );
endinterface

// File: rtl/collision_score.sv
// Collision detection against two pipes and the floor, game FSM, per-game score and session high score.
module collision_score #(
   parameter int unsigned PIPE_W       = 60,
   parameter int unsigned GAP_H        = 120,
   parameter int unsigned BIRD_X       = 200,
   parameter int unsigned BIRD_SZ      = 20,
   parameter int unsigned FLOOR_Y      = 460,
   parameter int unsigned GRACE_CYCLES = 25000000
) (
   input  logic              Clk,
   input  logic              Reset,
   collision_score_if.slave  bus
);

   localparam logic [10:0] BIRD_L     = 11'(BIRD_X);
   localparam logic [10:0] BIRD_R     = 11'(BIRD_X + BIRD_SZ - 1);
   localparam logic [10:0] PIPE_SPAN  = 11'(PIPE_W - 1);
   localparam logic [10:0] GAP_SPAN   = 11'(GAP_H);
   localparam logic [10:0] BIRD_SPAN  = 11'(BIRD_SZ);
   localparam logic [10:0] FLOOR_ROW  = 11'(FLOOR_Y);
   localparam logic [24:0] GRACE_LOAD = 25'(GRACE_CYCLES);

   typedef enum logic [2:0] {
      IDLE = 3'b001,
      PLAY = 3'b010,
      LOST = 3'b100
   } state_t;

   state_t      state, state_nxt;
   logic        lost, playing;
   logic [9:0]  score, score_nxt;
   logic [9:0]  high_score, high_score_nxt;
   logic [24:0] grace, grace_nxt;
   logic        armed, armed_nxt;
   logic        hit_r;
   logic [10:0] prev_right_a, prev_right_b;

   logic        hit_now;
   logic [10:0] right_a, right_b;
   logic        clear_a, clear_b;
   logic [11:0] score_sum;

   function automatic logic pipe_hit(input logic [9:0] px, input logic [9:0] py,
                                     input logic [9:0] by);
      logic [10:0] left, right, gap_top, gap_end, bird_top, bird_end;
      left     = {1'b0, px};
      right    = left + PIPE_SPAN;
      gap_top  = {1'b0, py};
      gap_end  = gap_top + GAP_SPAN;
      bird_top = {1'b0, by};
      bird_end = bird_top + BIRD_SPAN;
      return (left <= BIRD_R) && (right >= BIRD_L) &&
             ((bird_top < gap_top) || (bird_end > gap_end));
   endfunction

   assign hit_now = pipe_hit(bus.PipePosXA, bus.PipePosYA, bus.BirdPosY) ||
                    pipe_hit(bus.PipePosXB, bus.PipePosYB, bus.BirdPosY) ||
                    (({1'b0, bus.BirdPosY} + BIRD_SPAN) > FLOOR_ROW);

   assign right_a   = {1'b0, bus.PipePosXA} + PIPE_SPAN;
   assign right_b   = {1'b0, bus.PipePosXB} + PIPE_SPAN;
   assign clear_a   = armed && (prev_right_a >= BIRD_L) && (right_a < BIRD_L);
   assign clear_b   = armed && (prev_right_b >= BIRD_L) && (right_b < BIRD_L);
   assign score_sum = 12'(score) + 12'(clear_a) + 12'(clear_b);

   always_comb begin
      state_nxt      = state;
      score_nxt      = score;
      high_score_nxt = high_score;
      grace_nxt      = grace;
      armed_nxt      = armed;
      unique case (state)
         IDLE: begin
            if (bus.Start) begin
               state_nxt = PLAY;
               score_nxt = '0;
               grace_nxt = GRACE_LOAD;
               armed_nxt = 1'b0;
            end
         end
         PLAY: begin
            armed_nxt = 1'b1;
            score_nxt = (score_sum > 12'd1023) ? '1 : score_sum[9:0];
            if (grace != '0)
               grace_nxt = grace - 25'd1;
            else if (hit_r)
               state_nxt = LOST;
         end
         LOST: begin
            // Score is frozen in LOST, so comparing every LOST cycle equals comparing on entry.
            if (score > high_score)
               high_score_nxt = score;
            if (bus.Start)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state        <= IDLE;
         lost         <= 1'b0;
         playing      <= 1'b0;
         score        <= '0;
         high_score   <= '0;
         grace        <= '0;
         armed        <= 1'b0;
         hit_r        <= 1'b0;
         prev_right_a <= '0;
         prev_right_b <= '0;
      end else begin
         state        <= state_nxt;
         lost         <= (state_nxt == LOST);
         playing      <= (state_nxt == PLAY);
         score        <= score_nxt;
         high_score   <= high_score_nxt;
         grace        <= grace_nxt;
         armed        <= armed_nxt;
         hit_r        <= hit_now;
         prev_right_a <= right_a;
         prev_right_b <= right_b;
      end
   end

   assign bus.Lost      = lost;
   assign bus.Playing   = playing;
   assign bus.Score     = score;
   assign bus.HighScore = high_score;

endmodule
